wb_arb: RTL and testbench

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_arb.sv | 253 +++++++++++++++++++++++++
 tb/tb_wb_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb.sv
// -----------------------------------------------------------------------------
// wb_arb -- write-back arbiter for the register file
//
// Three producers compete for the single register-file write port:
//   * ALU     : unbuffered, always ready, wins the port whenever it is valid.
//   * mul/div : buffered in its own FIFO_DEPTH-entry FIFO.
//   * LSU     : buffered in its own FIFO_DEPTH-entry FIFO.
// When the ALU is idle, one non-empty FIFO head is written per cycle. The two
// FIFOs share the port by round-robin on a 1-bit last_grant flop.
//
// Parameters
//   FIFO_DEPTH    entries per buffered source (power of two, >= 2)
//
// Ports
//   clk           sole clock, rising edge
//   rst           asynchronous, active-low reset
//   alu2wb_*      ALU result handshake (rdy tied high), data, destination index
//   div2wb_*      mul/div result handshake, data, destination index
//   lsu2wb_*      load result handshake, data, destination index
//   wb2regs_wen   register-file write enable (low for index 0)
//   wb2regs_waddr register-file write index (zero when nothing is granted)
//   wb2regs_wdata register-file write data  (zero when nothing is granted)
//   wb_busy       high while either FIFO holds an entry
// -----------------------------------------------------------------------------

`ifndef MYRISCV_REGBUS
`define MYRISCV_REGBUS 31:0
`endif

`ifndef MYRISCV_REGADDRBUS
`define MYRISCV_REGADDRBUS 4:0
`endif

// -----------------------------------------------------------------------------
// wb_arb_fifo -- small synchronous FIFO used for the buffered sources
//
// Ports
//   clk, rst      clock and asynchronous active-low reset
//   push          write push_data at the tail (caller guarantees !full)
//   push_data     entry to store
//   pop           drop the head entry (caller guarantees not_empty)
//   head_data     current head entry
//   full          registered count equals DEPTH
//   not_empty     registered count is non-zero
// -----------------------------------------------------------------------------
module wb_arb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             not_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Entry storage carries no reset; the pointers and count alone decide
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. A push and a
    // pop in the same cycle advance both pointers and leave count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);

endmodule

// -----------------------------------------------------------------------------
// wb_arb -- top level
// -----------------------------------------------------------------------------
module wb_arb #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       alu2wb_vld,
    output logic                       alu2wb_rdy,
    input  logic [`MYRISCV_REGBUS]     alu2wb_data,
    input  logic [`MYRISCV_REGADDRBUS] alu2wb_rdidx,

    input  logic                       div2wb_vld,
    output logic                       div2wb_rdy,
    input  logic [`MYRISCV_REGBUS]     div2wb_data,
    input  logic [`MYRISCV_REGADDRBUS] div2wb_rdidx,

    input  logic                       lsu2wb_vld,
    output logic                       lsu2wb_rdy,
    input  logic [`MYRISCV_REGBUS]     lsu2wb_data,
    input  logic [`MYRISCV_REGADDRBUS] lsu2wb_rdidx,

    output logic                       wb2regs_wen,
    output logic [`MYRISCV_REGADDRBUS] wb2regs_waddr,
    output logic [`MYRISCV_REGBUS]     wb2regs_wdata,
    output logic                       wb_busy
);

    localparam int DW = $bits(alu2wb_data);
    localparam int AW = $bits(alu2wb_rdidx);
    localparam int EW = AW + DW;

    logic          div_full;
    logic          div_not_empty;
    logic [EW-1:0] div_head;
    logic          lsu_full;
    logic          lsu_not_empty;
    logic [EW-1:0] lsu_head;

    logic          div_push;
    logic          lsu_push;

    logic          grant_alu;
    logic          grant_div;
    logic          grant_lsu;

    // 0 = div was granted last, 1 = lsu was granted last.
    logic          last_grant;

    logic [AW-1:0] sel_idx;
    logic [DW-1:0] sel_data;

    // Ready comes only from the registered FIFO count, so a full FIFO refuses
    // a new entry even in a cycle where its head is being popped.
    assign alu2wb_rdy = 1'b1;
    assign div2wb_rdy = !div_full;
    assign lsu2wb_rdy = !lsu_full;

    assign div_push = div2wb_vld && !div_full;
    assign lsu_push = lsu2wb_vld && !lsu_full;

    wb_arb_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .WIDTH     (EW)
    ) u_div_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (div_push),
        .push_data ({div2wb_rdidx, div2wb_data}),
        .pop       (grant_div),
        .head_data (div_head),
        .full      (div_full),
        .not_empty (div_not_empty)
    );

    wb_arb_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .WIDTH     (EW)
    ) u_lsu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (lsu_push),
        .push_data ({lsu2wb_rdidx, lsu2wb_data}),
        .pop       (grant_lsu),
        .head_data (lsu_head),
        .full      (lsu_full),
        .not_empty (lsu_not_empty)
    );

    // Per-cycle grant: ALU first, then the FIFO heads by round-robin.
    // Everything is gated by rst so an ALU valid held during reset cannot
    // reach the register file.
    always_comb begin
        grant_alu = 1'b0;
        grant_div = 1'b0;
        grant_lsu = 1'b0;
        if (rst) begin
            if (alu2wb_vld) begin
                grant_alu = 1'b1;
            end else if (div_not_empty && lsu_not_empty) begin
                if (last_grant) begin
                    grant_div = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else if (div_not_empty) begin
                grant_div = 1'b1;
            end else if (lsu_not_empty) begin
                grant_lsu = 1'b1;
            end
        end
    end

    // Write-port mux. Index 0 is still granted and popped but never written.
    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        if (grant_alu) begin
            sel_idx  = alu2wb_rdidx;
            sel_data = alu2wb_data;
        end else if (grant_div) begin
            sel_idx  = div_head[EW-1:DW];
            sel_data = div_head[DW-1:0];
        end else if (grant_lsu) begin
            sel_idx  = lsu_head[EW-1:DW];
            sel_data = lsu_head[DW-1:0];
        end
    end

    assign wb2regs_wen   = (grant_alu || grant_div || grant_lsu) && (sel_idx != '0);
    assign wb2regs_waddr = sel_idx;
    assign wb2regs_wdata = sel_data;

    // Round-robin memory: only FIFO grants move it; ALU grants leave it alone.
    // Reset value 0 means lsu is preferred when both FIFOs first compete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b0;
        end else if (grant_div) begin
            last_grant <= 1'b0;
        end else if (grant_lsu) begin
            last_grant <= 1'b1;
        end
    end

    assign wb_busy = div_not_empty || lsu_not_empty;

endmodule

// File: tb/tb_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_arb -- directed testbench for wb_arb
//
// Inputs are driven 1 time unit after each rising edge; combinational outputs
// are sampled on the following falling edge, i.e. within the same cycle.
// -----------------------------------------------------------------------------
module tb_wb_arb;

    logic        clk;
    logic        rst;
    logic        alu_vld;
    logic        alu_rdy;
    logic [31:0] alu_data;
    logic [4:0]  alu_idx;
    logic        div_vld;
    logic        div_rdy;
    logic [31:0] div_data;
    logic [4:0]  div_idx;
    logic        lsu_vld;
    logic        lsu_rdy;
    logic [31:0] lsu_data;
    logic [4:0]  lsu_idx;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        busy;

    int test_count;
    int fail_count;

    wb_arb #(
        .FIFO_DEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .alu2wb_vld    (alu_vld),
        .alu2wb_rdy    (alu_rdy),
        .alu2wb_data   (alu_data),
        .alu2wb_rdidx  (alu_idx),
        .div2wb_vld    (div_vld),
        .div2wb_rdy    (div_rdy),
        .div2wb_data   (div_data),
        .div2wb_rdidx  (div_idx),
        .lsu2wb_vld    (lsu_vld),
        .lsu2wb_rdy    (lsu_rdy),
        .lsu2wb_data   (lsu_data),
        .lsu2wb_rdidx  (lsu_idx),
        .wb2regs_wen   (wen),
        .wb2regs_waddr (waddr),
        .wb2regs_wdata (wdata),
        .wb_busy       (busy)
    );

    // 10-unit clock, first rising edge at time 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all source inputs for the current cycle.
    task automatic applyStimulus(
        input logic        a_v, input logic [4:0] a_i, input logic [31:0] a_d,
        input logic        d_v, input logic [4:0] d_i, input logic [31:0] d_d,
        input logic        l_v, input logic [4:0] l_i, input logic [31:0] l_d
    );
        alu_vld  = a_v;
        alu_idx  = a_i;
        alu_data = a_d;
        div_vld  = d_v;
        div_idx  = d_i;
        div_data = d_d;
        lsu_vld  = l_v;
        lsu_idx  = l_i;
        lsu_data = l_d;
    endtask

    // One comparison: counts it and reports a failure with tag and values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the whole write port plus busy in one call.
    task automatic checkPort(input string tag, input logic e_wen, input logic [4:0] e_addr,
                             input logic [31:0] e_data, input logic e_busy);
        checkOutput({tag, ".wen"},   {31'b0, wen},  {31'b0, e_wen});
        checkOutput({tag, ".waddr"}, {27'b0, waddr}, {27'b0, e_addr});
        checkOutput({tag, ".wdata"}, wdata,          e_data);
        checkOutput({tag, ".busy"},  {31'b0, busy}, {31'b0, e_busy});
    endtask

    task automatic checkReady(input string tag, input logic e_div, input logic e_lsu);
        checkOutput({tag, ".alu_rdy"}, {31'b0, alu_rdy}, 32'd1);
        checkOutput({tag, ".div_rdy"}, {31'b0, div_rdy}, {31'b0, e_div});
        checkOutput({tag, ".lsu_rdy"}, {31'b0, lsu_rdy}, {31'b0, e_lsu});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        test_count = 0;
        fail_count = 0;
        rst = 1'b0;
        // ALU valid while in reset must not produce a write.
        applyStimulus(1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        checkPort("reset", 1'b0, 5'd0, 32'h0, 1'b0);
        checkReady("reset", 1'b1, 1'b1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #10;
        rst = 1'b1;

        // Single div entry: written the cycle after the push, then idle.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("div1.push", 1'b0, 5'd0, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("div1.write", 1'b1, 5'd5, 32'h1234, 1'b1);
        nextCycle();
        sample();
        checkPort("div1.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // div and lsu push together: lsu first, div next, last_grant ends at 0.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
        sample();
        checkPort("rr.push", 1'b0, 5'd0, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("rr.lsu", 1'b1, 5'd7, 32'h77, 1'b1);
        nextCycle();
        sample();
        checkPort("rr.div", 1'b1, 5'd6, 32'h66, 1'b1);
        nextCycle();
        sample();
        checkPort("rr.idle", 1'b0, 5'd0, 32'h0, 1'b0);
        checkOutput("rr.last_grant", {31'b0, dut.last_grant}, 32'd0);

        // ALU holds the port 4 cycles while div offers 3 entries.
        nextCycle();
        applyStimulus(1'b1, 5'd1, 32'hA0, 1'b1, 5'd8, 32'hD0, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("alu.c0", 1'b1, 5'd1, 32'hA0, 1'b0);
        checkReady("alu.c0", 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd2, 32'hA1, 1'b1, 5'd9, 32'hD1, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("alu.c1", 1'b1, 5'd2, 32'hA1, 1'b1);
        checkReady("alu.c1", 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd3, 32'hA2, 1'b1, 5'd10, 32'hD2, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("alu.c2", 1'b1, 5'd3, 32'hA2, 1'b1);
        checkReady("alu.c2", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 5'd4, 32'hA3, 1'b1, 5'd10, 32'hD2, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("alu.c3", 1'b1, 5'd4, 32'hA3, 1'b1);
        checkReady("alu.c3", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hD2, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("alu.d0", 1'b1, 5'd8, 32'hD0, 1'b1);
        checkReady("alu.d0", 1'b0, 1'b1);
        nextCycle();
        sample();
        // Held third entry is accepted here while D1 pops in the same cycle.
        checkPort("alu.d1", 1'b1, 5'd9, 32'hD1, 1'b1);
        checkReady("alu.d1", 1'b1, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("alu.d2", 1'b1, 5'd10, 32'hD2, 1'b1);
        nextCycle();
        sample();
        checkPort("alu.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // lsu entry to index 0: granted and popped without a write.
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        sample();
        checkPort("x0.push", 1'b0, 5'd0, 32'h0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        checkOutput("x0.grant.wen", {31'b0, wen}, 32'd0);
        checkOutput("x0.grant.busy", {31'b0, busy}, 32'd1);
        nextCycle();
        sample();
        checkOutput("x0.after.busy", {31'b0, busy}, 32'd0);

        // Full div FIFO: a push offered in the pop cycle is refused.
        nextCycle();
        applyStimulus(1'b1, 5'd20, 32'hC0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 5'd21, 32'hC1, 1'b1, 5'd12, 32'hB1, 1'b0, 5'd0, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hB2, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("full.pop", 1'b1, 5'd11, 32'hB0, 1'b1);
        checkReady("full.pop", 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sample();
        checkPort("full.next", 1'b1, 5'd12, 32'hB1, 1'b1);
        checkReady("full.next", 1'b1, 1'b1);
        nextCycle();
        sample();
        checkPort("full.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // Both FIFOs full, then reset mid-operation discards everything.
        nextCycle();
        applyStimulus(1'b1, 5'd22, 32'hE0, 1'b1, 5'd14, 32'hF0, 1'b1, 5'd15, 32'hF1);
        nextCycle();
        applyStimulus(1'b1, 5'd23, 32'hE1, 1'b1, 5'd16, 32'hF2, 1'b1, 5'd17, 32'hF3);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkReady("rst.before", 1'b0, 1'b0);
        checkOutput("rst.before.busy", {31'b0, busy}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkPort("rst.mid", 1'b0, 5'd0, 32'h0, 1'b0);
        checkReady("rst.mid", 1'b1, 1'b1);
        nextCycle();
        sample();
        rst = 1'b1;
        nextCycle();
        sample();
        checkPort("rst.after1", 1'b0, 5'd0, 32'h0, 1'b0);
        nextCycle();
        sample();
        checkPort("rst.after2", 1'b0, 5'd0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
